mips_multicycle_core: RTL and testbench

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mips_alu32.sv | 26 ++
 rtl/mips_multicycle_core.sv | 165 ++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and enums for the multicycle MIPS core: opcodes, functs,
// FSM states and ALU operations.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_alu32.sv
// Combinational 32-bit ALU: wrap-around add/sub, and, or, signed slt, zero flag.
module mips_alu32
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = 32'd0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      default: y = 32'd0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core on a unified req/ack memory; FSM, register
// file and datapath inline, ALU in mips_alu32.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] retired,
  output state_e      dbg_state
);

  state_e      state, state_next;
  logic [31:0] ir, a_q, b_q, res_q, pc_q, retired_q;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic [31:0] imm_ext, rd_a, rd_b, alu_b, alu_y, branch_target, jump_target;
  logic        alu_zero, xfer;
  logic        is_r, is_jr, r_alu, is_addi, is_lw, is_sw, is_beq, is_j, is_jal, legal;
  alu_op_e     alu_op;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm_ext = sext16(ir[15:0]);

  assign is_r    = (opcode == OP_RTYPE);
  assign is_jr   = is_r && (funct == FN_JR);
  assign r_alu   = is_r && (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                            funct == FN_OR  || funct == FN_SLT);
  assign is_addi = (opcode == OP_ADDI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);
  assign legal   = r_alu | is_jr | is_addi | is_lw | is_sw | is_beq | is_j | is_jal;
  assign wb_dest = is_r ? rd : rt;

  // Memory handshake: a request is held (addr/we/wdata frozen) while mem_req=1
  // and completes on the rising edge where mem_req=1 and mem_ack=1.
  assign xfer = mem_req && mem_ack;

  assign rd_a = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd_b = (rt == 5'd0) ? 32'd0 : rf[rt];

  // pc already holds PC+4 once the fetch completes, so targets build on it.
  assign branch_target = pc_q + (imm_ext << 2);
  assign jump_target   = {pc_q[31:28], ir[25:0], 2'b00};

  assign alu_b = (r_alu || is_beq) ? b_q : imm_ext;

  always_comb begin
    alu_op = ALU_ADD;
    if (is_beq) alu_op = ALU_SUB;
    else if (r_alu) begin
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  mips_alu32 u_alu (
    .a    (a_q),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (xfer) state_next = S_DECODE;
      S_DECODE: state_next = (!legal && HALT_ON_ILLEGAL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw)         state_next = S_MEM;
        else if (r_alu || is_addi)  state_next = S_WB;
        else                        state_next = S_FETCH;
      end
      S_MEM:    if (xfer) state_next = is_lw ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = Rst_n && (state == S_FETCH || state == S_MEM);
    mem_we    = mem_req && (state == S_MEM) && is_sw;
    mem_addr  = 32'd0;
    if (mem_req) mem_addr = (state == S_FETCH) ? pc_q : {res_q[31:2], 2'b00};
    mem_wdata = mem_we ? b_q : 32'd0;
    halted    = (state == S_HALT);
    dbg_state = state;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pc_q      <= RESET_PC;
      ir        <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      res_q     <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      if (state_next == S_FETCH && state != S_FETCH) retired_q <= retired_q + 32'd1;
      case (state)
        S_FETCH: if (xfer) begin
          ir   <= mem_rdata;
          pc_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
        end
        S_EXEC: begin
          res_q <= alu_y;
          if (is_beq && alu_zero)  pc_q <= branch_target;
          else if (is_j || is_jal) pc_q <= jump_target;
          else if (is_jr)          pc_q <= a_q;
        end
        S_MEM: if (xfer && is_lw) res_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (state == S_WB && wb_dest != 5'd0) begin
      rf[wb_dest] <= res_q;
    end else if (state == S_EXEC && is_jal) begin
      rf[31] <= pc_q;
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs in a req/ack memory
// model, checked cycle-by-cycle against hand-computed expectations.
module tb_mips_multicycle_core;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;
  state_e      dbg_state;

  mips_multicycle_core #(.RESET_PC(RPC), .HALT_ON_ILLEGAL(1'b1)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .halted    (halted),
    .retired   (retired),
    .dbg_state (dbg_state)
  );

  // clock / memory model
  always #5 Clk = ~Clk;

  logic [31:0] mem      [0:255];
  logic [31:0] init_mem [0:255];
  logic        load_en = 1'b0;
  int          wait_cycles = 0;
  int          wait_cnt = 0;

  assign mem_ack   = mem_req && (wait_cnt >= wait_cycles);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge Clk) begin
    if (load_en) mem <= init_mem;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // scoreboard state
  typedef enum int {K_PC, K_REG, K_RET, K_HALT, K_REQ, K_MEM} kind_e;
  typedef struct {
    int          prog;
    int          at;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cycle = 0;
  logic        pend = 1'b0;
  logic [64:0] saved = '0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic add_vec(input int p, input int at, input kind_e k, input int idx,
                         input logic [31:0] exp);
    vec_t v;
    v.prog = p; v.at = at; v.kind = k; v.idx = idx; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, then check that any
  // request left waiting at the previous sample is still presented unchanged.
  task automatic tick();
    logic [64:0] cur;
    @(posedge Clk);
    #1;
    cycle++;
    cur = {mem_we, mem_addr, mem_wdata};
    if (!Rst_n) pend = 1'b0;
    else begin
      if (pend) begin
        n_cmp++;
        if (!mem_req || cur !== saved) begin
          n_fail++;
          $display("FAIL mem_stable c%0d: got req=%b %h expected req=1 %h",
                   cycle, mem_req, cur, saved);
        end
      end
      pend  = mem_req && !mem_ack;
      saved = cur;
    end
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 256; i++) init_mem[i] = 32'd0;
    init_mem[2] = 32'hDEAD_BEEF;
    case (p)
      0: begin
        wait_cycles  = 0;
        init_mem[64] = i_ins(OP_ADDI, 0, 1, 16'd5);
        init_mem[65] = i_ins(OP_ADDI, 0, 2, 16'hFFFD);
        init_mem[66] = r_ins(1, 2, 3, FN_ADD);
        init_mem[67] = r_ins(2, 1, 4, FN_SLT);
        init_mem[68] = r_ins(1, 2, 6, FN_SUB);
        init_mem[69] = r_ins(1, 2, 7, FN_AND);
        init_mem[70] = r_ins(1, 2, 8, FN_OR);
        init_mem[71] = r_ins(1, 2, 9, FN_SLT);
        init_mem[72] = r_ins(1, 1, 0, FN_ADD);
        init_mem[73] = r_ins(0, 1, 10, FN_ADD);
        init_mem[74] = i_ins(OP_BEQ, 0, 0, 16'hFFFF);
      end
      1: begin
        wait_cycles  = 0;
        init_mem[64] = r_ins(31, 0, 0, FN_JR);
        init_mem[0]  = i_ins(OP_BEQ, 0, 0, 16'd2);
        init_mem[3]  = j_ins(OP_JAL, 26'h40);
        init_mem[4]  = j_ins(6'h3F, 26'd0);
      end
      default: begin
        wait_cycles  = 3;
        init_mem[64] = i_ins(OP_ADDI, 0, 3, 16'd2);
        init_mem[65] = i_ins(OP_SW, 0, 3, 16'd8);
        init_mem[66] = i_ins(OP_LW, 0, 5, 16'd8);
        init_mem[67] = i_ins(OP_BEQ, 5, 0, 16'd1);
        init_mem[68] = i_ins(OP_BEQ, 0, 0, 16'hFFFF);
      end
    endcase
  endtask

  task automatic do_reset(input int p);
    load_prog(p);
    Rst_n   = 1'b0;
    load_en = 1'b1;
    tick();
    tick();
    load_en = 1'b0;
    tick();
    check($sformatf("p%0d_rst_req", p), {31'd0, mem_req}, 32'd0);
    check($sformatf("p%0d_rst_pc", p), pc, RPC);
    check($sformatf("p%0d_rst_retired", p), retired, 32'd0);
    check($sformatf("p%0d_rst_halted", p), {31'd0, halted}, 32'd0);
    Rst_n = 1'b1;
    cycle = 0;
    #1;
    check($sformatf("p%0d_first_req", p), {31'd0, mem_req}, 32'd1);
    check($sformatf("p%0d_first_addr", p), mem_addr, RPC);
  endtask

  task automatic run_prog(input int p);
    do_reset(p);
    foreach (vecs[i]) begin
      if (vecs[i].prog == p) begin
        string nm;
        while (cycle < vecs[i].at) tick();
        nm = $sformatf("p%0d_c%0d_%s%0d", p, cycle, vecs[i].kind.name(), vecs[i].idx);
        case (vecs[i].kind)
          K_PC:    check(nm, pc, vecs[i].exp);
          K_REG:   check(nm, dut.rf[vecs[i].idx], vecs[i].exp);
          K_RET:   check(nm, retired, vecs[i].exp);
          K_HALT:  check(nm, {31'd0, halted}, vecs[i].exp);
          K_REQ:   check(nm, {31'd0, mem_req}, vecs[i].exp);
          default: check(nm, mem[vecs[i].idx], vecs[i].exp);
        endcase
      end
    end
  endtask

  initial begin
    // program 0: arithmetic, $0 protection
    add_vec(0,  4, K_REG, 1, 32'd5);
    add_vec(0,  4, K_RET, 0, 32'd1);
    add_vec(0,  8, K_REG, 2, 32'hFFFF_FFFD);
    add_vec(0, 12, K_REG, 3, 32'd2);
    add_vec(0, 15, K_RET, 0, 32'd3);
    add_vec(0, 16, K_REG, 4, 32'd1);
    add_vec(0, 16, K_RET, 0, 32'd4);
    add_vec(0, 16, K_PC,  0, 32'h0000_0110);
    add_vec(0, 20, K_REG, 6, 32'd8);
    add_vec(0, 24, K_REG, 7, 32'd5);
    add_vec(0, 28, K_REG, 8, 32'hFFFF_FFFD);
    add_vec(0, 32, K_REG, 9, 32'd0);
    add_vec(0, 36, K_REG, 0, 32'd0);
    add_vec(0, 40, K_REG, 10, 32'd5);
    add_vec(0, 43, K_PC,  0, 32'h0000_0128);
    add_vec(0, 43, K_RET, 0, 32'd11);
    // program 1: jr / beq / jal / jr, then illegal opcode
    add_vec(1,  3, K_PC,  0, 32'h0000_0000);
    add_vec(1,  6, K_PC,  0, 32'h0000_000C);
    add_vec(1,  9, K_PC,  0, 32'h0000_0100);
    add_vec(1,  9, K_REG, 31, 32'h0000_0010);
    add_vec(1, 12, K_PC,  0, 32'h0000_0010);
    add_vec(1, 12, K_RET, 0, 32'd4);
    add_vec(1, 13, K_HALT, 0, 32'd0);
    add_vec(1, 14, K_HALT, 0, 32'd1);
    add_vec(1, 14, K_RET, 0, 32'd4);
    add_vec(1, 20, K_REQ, 0, 32'd0);
    add_vec(1, 20, K_HALT, 0, 32'd1);
    add_vec(1, 20, K_RET, 0, 32'd4);
    add_vec(1, 20, K_PC,  0, 32'h0000_0014);
    // program 2: sw/lw with 3 wait cycles per request, not-taken beq
    add_vec(2,  7, K_REG, 3, 32'd2);
    add_vec(2, 16, K_MEM, 2, 32'hDEAD_BEEF);
    add_vec(2, 17, K_MEM, 2, 32'd2);
    add_vec(2, 17, K_RET, 0, 32'd2);
    add_vec(2, 27, K_RET, 0, 32'd2);
    add_vec(2, 28, K_REG, 5, 32'd2);
    add_vec(2, 28, K_RET, 0, 32'd3);
    add_vec(2, 34, K_PC,  0, 32'h0000_0110);
    add_vec(2, 34, K_RET, 0, 32'd4);

    run_prog(0);
    run_prog(1);
    run_prog(2);

    // reset while the store of program 2 is waiting in MEM
    do_reset(2);
    while (cycle < 14) tick();
    check("mid_state", {29'd0, dbg_state}, {29'd0, S_MEM});
    check("mid_we", {31'd0, mem_we}, 32'd1);
    Rst_n = 1'b0;
    tick();
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_pc", pc, RPC);
    check("mid_rst_r3", dut.rf[3], 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("mid_rst_nostore", mem[2], 32'hDEAD_BEEF);
    Rst_n = 1'b1;
    cycle = 0;
    #1;
    check("mid_rel_req", {31'd0, mem_req}, 32'd1);
    check("mid_rel_addr", mem_addr, RPC);
    while (cycle < 7) tick();
    check("mid_rel_r3", dut.rf[3], 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
